// File: rtl/green_cube_pkg.sv
// Shared constants, state encoding and init layout for the slime world engine.
package green_cube_pkg;

  localparam logic [10:0] SCREEN_W    = 11'd640;
  localparam logic [10:0] SCREEN_H    = 11'd480;
  localparam logic [10:0] SLIME_W     = 11'd20;
  localparam logic [10:0] SLIME_H     = 11'd20;
  localparam logic [10:0] FLOOR_W     = 11'd40;
  localparam logic [10:0] MOVE_STEP   = 11'd2;
  localparam logic [10:0] SCROLL_STEP = 11'd1;
  localparam logic [2:0]  GRAVITY     = 3'd1;
  localparam logic [2:0]  VMAX        = 3'd6;
  localparam logic [9:0]  LFSR_SEED   = 10'h2A5;

  localparam logic [10:0] X_MAX       = SCREEN_W - SLIME_W;
  localparam logic [10:0] SPAWN_X_MIN = 11'd40;

  localparam logic [10:0] SLIME_X0 = 11'd300;
  localparam logic [10:0] SLIME_Y0 = 11'd220;
  localparam logic [10:0] FLOOR_X0 [4] = '{11'd80, 11'd290, 11'd450, 11'd170};
  localparam logic [10:0] FLOOR_Y0 [4] = '{11'd100, 11'd220, 11'd340, 11'd460};

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

endpackage

// File: rtl/slime_world_ctrl_if.sv
// Controls in from the frame/input side, registered frame state out to the pixel generator.
interface slime_world_ctrl_if;
  logic        frame_tick;
  logic        start;
  logic        btn_left;
  logic        btn_right;
  logic [9:0]  slime_pos_x;
  logic [9:0]  slime_pos_y;
  logic [9:0]  floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3;
  logic [9:0]  floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3;
  logic [3:0]  enable;
  logic        game_over;
  logic [15:0] score;

  modport master (
    output frame_tick, start, btn_left, btn_right,
    input  slime_pos_x, slime_pos_y,
           floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
           floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
           enable, game_over, score
  );

  modport slave (
    input  frame_tick, start, btn_left, btn_right,
    output slime_pos_x, slime_pos_y,
           floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
           floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
           enable, game_over, score
  );
endinterface

// File: rtl/slime_world_ctrl_lfsr10.sv
// 10-bit Fibonacci LFSR (x^10 + x^7 + 1), free-running; load restores the seed.
module lfsr10 #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  output logic [9:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= SEED;
    else if (load) q <= SEED;
    else           q <= {q[8:0], q[9] ^ q[6]};
  end

endmodule

// File: rtl/slime_world_ctrl.sv
// Per-frame game-state engine: slime motion, scrolling floors, score and game-over.
module slime_world_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  slime_world_ctrl_if.slave sw
);
  import green_cube_pkg::*;

  state_t      state;
  logic [10:0] sx, sy;
  logic [10:0] fx [4];
  logic [10:0] fy [4];
  logic [2:0]  vel;
  logic        on_floor;
  logic [1:0]  floor_idx;
  logic [3:0]  en;
  logic [15:0] score;
  logic        game_over;
  logic [9:0]  lfsr_q;
  logic        reinit;

  logic [10:0] nx, ny, y_cand, spawn_x;
  logic [10:0] nfx [4];
  logic [10:0] nfy [4];
  logic [3:0]  spawned, ovl;
  logic [2:0]  n_spawn, n_vel;
  logic        n_on, found, die;
  logic [1:0]  n_idx;
  logic [15:0] score_n;

  assign reinit = (state == OVER) && sw.start;

  lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (reinit),
    .q     (lfsr_q)
  );

  assign spawn_x = 11'(lfsr_q & 10'h1FF) + SPAWN_X_MIN;

  always_comb begin
    nx = sx;
    if (sw.btn_left && !sw.btn_right)
      nx = (sx < MOVE_STEP) ? '0 : sx - MOVE_STEP;
    else if (sw.btn_right && !sw.btn_left)
      nx = (sx > X_MAX - MOVE_STEP) ? X_MAX : sx + MOVE_STEP;

    n_spawn = '0;
    spawned = '0;
    ovl     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      nfx[i] = fx[i];
      nfy[i] = fy[i] - SCROLL_STEP;
      if (fy[i] == '0) begin
        nfx[i]     = spawn_x;
        nfy[i]     = SCREEN_H;
        spawned[i] = 1'b1;
        n_spawn    = n_spawn + 3'd1;
      end
      ovl[i] = (nx < nfx[i] + FLOOR_W) && (nx + SLIME_W > nfx[i]);
    end

    n_vel  = vel;
    n_on   = on_floor;
    n_idx  = floor_idx;
    found  = 1'b0;
    y_cand = sy;
    ny     = sy;
    if (on_floor && ovl[floor_idx] && !spawned[floor_idx]) begin
      ny    = nfy[floor_idx];
      n_vel = '0;
    end else begin
      n_on   = 1'b0;
      n_vel  = (vel + GRAVITY > VMAX) ? VMAX : vel + GRAVITY;
      y_cand = sy + {8'b0, n_vel};
      ny     = y_cand;
      // Strict < keeps the lowest index on equal floor heights.
      for (int unsigned i = 0; i < 4; i++) begin
        if (en[i] && ovl[i] && nfy[i] >= sy && nfy[i] <= y_cand && (!found || nfy[i] < ny)) begin
          found = 1'b1;
          ny    = nfy[i];
          n_idx = 2'(i);
        end
      end
      if (found) begin
        n_vel = '0;
        n_on  = 1'b1;
      end
    end

    die     = (ny <= SLIME_H) || (ny >= SCREEN_H + SLIME_H);
    score_n = (score > 16'hFFFF - 16'(n_spawn)) ? 16'hFFFF : score + 16'(n_spawn);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      game_over <= 1'b0;
      score     <= '0;
      sx        <= SLIME_X0;
      sy        <= SLIME_Y0;
      vel       <= '0;
      on_floor  <= 1'b1;
      floor_idx <= 2'd1;
      en        <= '1;
      for (int unsigned i = 0; i < 4; i++) begin
        fx[i] <= FLOOR_X0[i];
        fy[i] <= FLOOR_Y0[i];
      end
    end else begin
      unique case (state)
        IDLE: if (sw.start) state <= PLAY;
        PLAY: if (sw.frame_tick) begin
          sx        <= nx;
          sy        <= ny;
          vel       <= n_vel;
          on_floor  <= n_on;
          floor_idx <= n_idx;
          score     <= score_n;
          for (int unsigned i = 0; i < 4; i++) begin
            fx[i] <= nfx[i];
            fy[i] <= nfy[i];
          end
          if (die) begin
            state     <= OVER;
            game_over <= 1'b1;
          end
        end
        OVER: if (sw.start) begin
          state     <= PLAY;
          game_over <= 1'b0;
          score     <= '0;
          sx        <= SLIME_X0;
          sy        <= SLIME_Y0;
          vel       <= '0;
          on_floor  <= 1'b1;
          floor_idx <= 2'd1;
          en        <= '1;
          for (int unsigned i = 0; i < 4; i++) begin
            fx[i] <= FLOOR_X0[i];
            fy[i] <= FLOOR_Y0[i];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sw.slime_pos_x  = sx[9:0];
  assign sw.slime_pos_y  = sy[9:0];
  assign sw.floor_pos_x0 = fx[0][9:0];
  assign sw.floor_pos_x1 = fx[1][9:0];
  assign sw.floor_pos_x2 = fx[2][9:0];
  assign sw.floor_pos_x3 = fx[3][9:0];
  assign sw.floor_pos_y0 = fy[0][9:0];
  assign sw.floor_pos_y1 = fy[1][9:0];
  assign sw.floor_pos_y2 = fy[2][9:0];
  assign sw.floor_pos_y3 = fy[3][9:0];
  assign sw.enable       = en;
  assign sw.game_over    = game_over;
  assign sw.score        = score;

endmodule

// File: tb/tb_slime_world_ctrl.sv
// Bench for slime_world_ctrl: directed scenarios plus random play against a frame-level model.
module tb_slime_world_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slime_world_ctrl_if sw ();

  slime_world_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural world model in plain integers.
  int         mx, my, mvel, midx, mscore;
  bit         mon, m_play, m_over;
  int         mfx [4];
  int         mfy [4];
  logic [9:0] mlfsr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] lfsr_next(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  function automatic bit hits(input int x, input int fxv);
    return (x < fxv + 40) && (x + 20 > fxv);
  endfunction

  task automatic model_init();
    mx = 300; my = 220; mvel = 0; mon = 1'b1; midx = 1; mscore = 0;
    mfx = '{80, 290, 450, 170};
    mfy = '{100, 220, 340, 460};
    mlfsr = 10'h2A5;
  endtask

  task automatic model_frame(input bit l, input bit r);
    bit resp [4];
    int cand, pick;
    if (l && !r)      mx = (mx < 2) ? 0 : mx - 2;
    else if (r && !l) mx = (mx + 2 > 620) ? 620 : mx + 2;
    for (int i = 0; i < 4; i++) begin
      resp[i] = 1'b0;
      if (mfy[i] == 0) begin
        mfy[i] = 480;
        mfx[i] = int'(mlfsr[8:0]) + 40;
        resp[i] = 1'b1;
        if (mscore < 65535) mscore++;
      end else begin
        mfy[i]--;
      end
    end
    if (mon && hits(mx, mfx[midx]) && !resp[midx]) begin
      my = mfy[midx];
      mvel = 0;
    end else begin
      mon  = 1'b0;
      mvel = (mvel + 1 > 6) ? 6 : mvel + 1;
      cand = my + mvel;
      pick = -1;
      for (int i = 0; i < 4; i++)
        if (hits(mx, mfx[i]) && mfy[i] >= my && mfy[i] <= cand && (pick < 0 || mfy[i] < mfy[pick]))
          pick = i;
      if (pick >= 0) begin
        my = mfy[pick]; mvel = 0; mon = 1'b1; midx = pick;
      end else begin
        my = cand;
      end
    end
    if (my <= 20 || my >= 500) begin
      m_play = 1'b0;
      m_over = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("slime_x", sw.slime_pos_x, 10'(mx));
    check("slime_y", sw.slime_pos_y, 10'(my));
    check("floor_x", {sw.floor_pos_x0, sw.floor_pos_x1, sw.floor_pos_x2, sw.floor_pos_x3},
          {10'(mfx[0]), 10'(mfx[1]), 10'(mfx[2]), 10'(mfx[3])});
    check("floor_y", {sw.floor_pos_y0, sw.floor_pos_y1, sw.floor_pos_y2, sw.floor_pos_y3},
          {10'(mfy[0]), 10'(mfy[1]), 10'(mfy[2]), 10'(mfy[3])});
    check("score", sw.score, 16'(mscore));
    check("game_over", sw.game_over, m_over);
    check("enable", sw.enable, 4'hF);
  endtask

  task automatic step(input bit ft, input bit st, input bit l, input bit r);
    sw.frame_tick = ft; sw.start = st; sw.btn_left = l; sw.btn_right = r;
    @(posedge clk);
    if (m_over) begin
      if (st) begin
        model_init();
        m_over = 1'b0;
        m_play = 1'b1;
      end else begin
        mlfsr = lfsr_next(mlfsr);
      end
    end else if (!m_play) begin
      if (st) m_play = 1'b1;
      mlfsr = lfsr_next(mlfsr);
    end else begin
      if (ft) model_frame(l, r);
      mlfsr = lfsr_next(mlfsr);
    end
    #1;
    sw.frame_tick = 1'b0;
    sw.start      = 1'b0;
    compare_all();
  endtask

  initial begin
    bit ft, st, l, r;
    sw.frame_tick = 1'b0; sw.start = 1'b0; sw.btn_left = 1'b0; sw.btn_right = 1'b0;
    model_init();
    m_play = 1'b0; m_over = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    compare_all();
    check("rst_x", sw.slime_pos_x, 10'd300);
    check("rst_f3y", sw.floor_pos_y3, 10'd460);

    // start and frame_tick together: transition only
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("st_tick_y", sw.slime_pos_y, 10'd220);
    check("st_tick_f0y", sw.floor_pos_y0, 10'd100);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_x", sw.slime_pos_x, 10'd300);
    check("t1_y", sw.slime_pos_y, 10'd219);
    check("t1_f1y", sw.floor_pos_y1, 10'd219);
    check("t1_f0y", sw.floor_pos_y0, 10'd99);
    check("t1_score", sw.score, 16'd0);

    repeat (99) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t100_f0y", sw.floor_pos_y0, 10'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t101_f0y", sw.floor_pos_y0, 10'd480);
    check("t101_score", sw.score, 16'd1);
    check("t101_f0x_range", (sw.floor_pos_x0 >= 10'd40) && (sw.floor_pos_x0 <= 10'd551), 1'b1);

    // ride floor1 to the ceiling
    repeat (98) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t199_over", sw.game_over, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("ceil_y", sw.slime_pos_y, 10'd20);
    check("ceil_over", sw.game_over, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b1, 1'b0);
    check("frozen_y", sw.slime_pos_y, 10'd20);
    check("frozen_x", sw.slime_pos_x, 10'd300);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_score", sw.score, 16'd0);
    check("restart_y", sw.slime_pos_y, 10'd220);
    check("restart_over", sw.game_over, 1'b0);

    // walk right off floor1 and fall
    repeat (25) step(1'b1, 1'b0, 1'b0, 1'b1);
    check("walk_x", sw.slime_pos_x, 10'd350);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (80) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // left held to the wall
    repeat (200) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    l = 1'b0; r = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      ft = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 11) == 0) begin
        l = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
      end
      step(ft, st, l, r);
    end

    // asynchronous reset mid-play
    if (!m_play) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (30) step(1'b1, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    model_init();
    m_play = 1'b0; m_over = 1'b0;
    compare_all();
    check("async_rst_y", sw.slime_pos_y, 10'd220);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_ignores_tick", sw.slime_pos_y, 10'd220);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
